seg7_to_tc4: RTL and testbench
==============================

SEG7_TO_TC4 -- requirements
Module: seg7_to_tc4

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive clock edges an input pair must be identical before it is decoded (legal range 2..15).
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Sign, input, 7 bits: active-low sign digit pattern, segments 6..0.
REQ-005 SHALL have port Magnitude, input, 7 bits: active-low magnitude digit pattern, segments 6..0.
REQ-006 SHALL have port Ready, input, 1 bit: the consumer accepts the offered result on an edge where Valid=1 and Ready=1.
REQ-007 SHALL have port N, output, 4 bits: decoded two's-complement value.
REQ-008 SHALL have port Valid, output, 1 bit: N and Error hold an offered result.
REQ-009 SHALL have port Error, output, 1 bit: the offered pair is not a legal encoding.
REQ-010 SHALL have port ErrCount, output, 4 bits: saturating count of accepted results with Error=1.

Function
REQ-011 SHALL decode magnitude patterns 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7 and 0000000=8.
REQ-012 SHALL treat Sign=1111111 as positive and Sign=0111111 as negative.
REQ-013 SHALL map a legal positive pair to N equal to the magnitude, for magnitudes 0..7.
REQ-014 SHALL map a legal negative pair to N equal to the 4-bit two's complement of the magnitude, for magnitudes 1..8 (so -8 gives 1000).
REQ-015 SHALL flag the following as illegal, giving Error=1 and N=0000: positive with 8; negative with 0; any other Sign pattern; any other non-blank Magnitude pattern.
REQ-016 SHALL treat Magnitude=1111111 (blank) as no-display: a blank pair is never offered, and the block remains in TRACK.
REQ-017 SHALL keep a sample register SR holding {Sign,Magnitude}, loaded every edge while in TRACK.
REQ-018 SHALL keep a match counter MC: an edge where inputs differ from SR clears it to 0; an edge where inputs equal SR increments it.
REQ-019 SHALL implement FSM states TRACK, OFFER and DONE.
REQ-020 SHALL transition TRACK->OFFER on the edge where the inputs equal SR, MC=STABLE_CYCLES-2 and the pair is non-blank; on that edge it latches the pair into LR and loads N and Error.
REQ-021 SHALL therefore assert Valid one cycle after the STABLE_CYCLES-th consecutive identical edge (for default 4: a pair stable from edge 0 gives Valid high after edge 3).
REQ-022 SHALL, in OFFER, hold Valid=1 and keep N and Error constant regardless of input changes until accepted.
REQ-023 SHALL, on an OFFER edge with Ready=1, go to DONE, clear Valid next cycle, and increment ErrCount if Error=1, saturating at 15.
REQ-024 SHALL, in DONE, go to TRACK with MC=0 on the first edge where the inputs differ from LR; an unchanged pair is never re-offered.
REQ-025 SHALL re-trigger the same pair only after a change to a different pair followed by a return to the original.
REQ-026 SHALL never assert Valid in TRACK or DONE.
REQ-027 SHALL accept combinationally on the offer cycle when Ready is already high (Valid high exactly one cycle).

Reset
REQ-028 SHALL, when Reset=1 on an edge, force state=TRACK, MC=0, SR=LR=all ones, N=0000, Valid=0, Error=0 and ErrCount=0, in any state including OFFER.
REQ-029 SHALL give Reset priority over Ready and over input changes on the same edge.

Verification
REQ-030 SHALL be checked with Sign=1111111 and Magnitude=0010010 held, Ready=1 -> Valid high exactly one cycle after edge 3, N=0101, Error=0.
REQ-031 SHALL be checked with Sign=0111111 and Magnitude=0000000 held -> N=1000, Error=0; and with Sign=0111111, Magnitude=1111001 -> N=1111.
REQ-032 SHALL be checked with Ready=0 for 5 cycles after Valid while Magnitude changes -> Valid, N and Error stay constant; Valid drops the cycle after Ready=1.
REQ-033 SHALL be checked with Magnitude toggled after 2 stable edges -> no Valid until 4 consecutive identical edges of the new pair.
REQ-034 SHALL be checked with Sign=1111111 and Magnitude=0000000, accepted -> Error=1, N=0000, ErrCount=1; repeating this 20 times -> ErrCount=15.
REQ-035 SHALL be checked with Reset=1 during OFFER -> Valid=0 and ErrCount=0 next cycle; a blank Magnitude held for 10 cycles -> Valid never asserts.

Source files
------------

// File: rtl/seg7_to_tc4.sv
// -----------------------------------------------------------------------------
// seg7_to_tc4
//
// Reads a two-digit seven-segment display (a sign digit and a magnitude digit,
// both active-low, segments 6..0), waits until the pair has been stable for
// STABLE_CYCLES consecutive clock edges, and offers the decoded value as a
// 4-bit two's-complement number through a Valid/Ready handshake. Each stable
// pair is offered once; it is offered again only after the display has shown
// something else in between.
//
// Parameters
//   STABLE_CYCLES  consecutive identical edges needed before decoding (2..15)
//
// Ports
//   Clock      in   single clock, rising edge
//   Reset      in   synchronous, active-high reset
//   Sign       in   [6:0] active-low sign digit (1111111 = +, 0111111 = -)
//   Magnitude  in   [6:0] active-low magnitude digit (1111111 = blank)
//   Ready      in   consumer takes the offered result when Valid & Ready
//   N          out  [3:0] decoded two's-complement value (0000 on error)
//   Valid      out  N/Error hold an offered result
//   Error      out  offered pair was not a legal encoding
//   ErrCount   out  [3:0] saturating count of accepted results with Error=1
// -----------------------------------------------------------------------------
module seg7_to_tc4 #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [6:0] Sign,
    input  logic [6:0] Magnitude,
    input  logic       Ready,
    output logic [3:0] N,
    output logic       Valid,
    output logic       Error,
    output logic [3:0] ErrCount
);

    // Active-low digit patterns.
    localparam logic [6:0] SIGN_POS  = 7'b1111111;
    localparam logic [6:0] SIGN_NEG  = 7'b0111111;
    localparam logic [6:0] MAG_BLANK = 7'b1111111;

    // The pair is decoded on the edge where MC already counts STABLE_CYCLES-2
    // earlier matches: the first edge of a new pair clears MC, each further
    // identical edge increments it, so this is the STABLE_CYCLES-th edge.
    localparam logic [3:0] MC_TRIGGER = 4'(STABLE_CYCLES - 2);
    localparam logic [3:0] CNT_MAX    = 4'hF;

    typedef enum logic [1:0] {
        TRACK = 2'd0,
        OFFER = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [13:0] sr;        // last sampled {Sign, Magnitude}
    logic [13:0] lr;        // pair that was offered most recently
    logic [3:0]  mc;        // consecutive-match counter

    logic [13:0] pair;
    logic        same_sr;
    logic        blank;

    logic [3:0]  mag_val;
    logic        mag_ok;
    logic [3:0]  dec_n;
    logic        dec_err;

    assign pair    = {Sign, Magnitude};
    assign same_sr = (pair == sr);
    assign blank   = (Magnitude == MAG_BLANK);

    // -------------------------------------------------------------------------
    // Digit decode: magnitude pattern -> value, then apply the sign.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default before the
        // case, otherwise an unlisted pattern would infer a latch.
        mag_val = 4'd0;
        mag_ok  = 1'b1;
        unique case (Magnitude)
            7'b1000000: mag_val = 4'd0;
            7'b1111001: mag_val = 4'd1;
            7'b0100100: mag_val = 4'd2;
            7'b0110000: mag_val = 4'd3;
            7'b0011001: mag_val = 4'd4;
            7'b0010010: mag_val = 4'd5;
            7'b0000010: mag_val = 4'd6;
            7'b1111000: mag_val = 4'd7;
            7'b0000000: mag_val = 4'd8;
            default:    mag_ok  = 1'b0;
        endcase
    end

    always_comb begin
        dec_n   = 4'd0;
        dec_err = 1'b1;
        if (mag_ok && (Sign == SIGN_POS) && (mag_val != 4'd8)) begin
            // +8 does not fit in 4-bit two's complement.
            dec_n   = mag_val;
            dec_err = 1'b0;
        end else if (mag_ok && (Sign == SIGN_NEG) && (mag_val != 4'd0)) begin
            // -0 is not a legal display; -8 wraps to 1000 as intended.
            dec_n   = 4'd0 - mag_val;
            dec_err = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Control: track stability, offer once, wait for the display to change.
    // -------------------------------------------------------------------------
    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples the values from before the edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= TRACK;
            sr       <= '1;
            lr       <= '1;
            mc       <= 4'd0;
            N        <= 4'd0;
            Valid    <= 1'b0;
            Error    <= 1'b0;
            ErrCount <= 4'd0;
        end else begin
            unique case (state)
                TRACK: begin
                    sr <= pair;
                    if (same_sr) begin
                        // Saturate so a long-held blank cannot wrap the count.
                        if (mc != CNT_MAX) begin
                            mc <= mc + 4'd1;
                        end
                        if ((mc == MC_TRIGGER) && !blank) begin
                            state <= OFFER;
                            lr    <= pair;
                            N     <= dec_n;
                            Error <= dec_err;
                            Valid <= 1'b1;
                        end
                    end else begin
                        mc <= 4'd0;
                    end
                end

                OFFER: begin
                    // Inputs are ignored here; N/Error stay frozen until taken.
                    if (Ready) begin
                        state <= DONE;
                        Valid <= 1'b0;
                        if (Error && (ErrCount != CNT_MAX)) begin
                            ErrCount <= ErrCount + 4'd1;
                        end
                    end
                end

                DONE: begin
                    // The edge that leaves DONE counts as the first sighting of
                    // the new pair, exactly like a differing edge in TRACK.
                    if (pair != lr) begin
                        state <= TRACK;
                        sr    <= pair;
                        mc    <= 4'd0;
                    end
                end

                default: begin
                    state <= TRACK;
                    mc    <= 4'd0;
                    Valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_to_tc4.sv
// -----------------------------------------------------------------------------
// tb_seg7_to_tc4
//
// Self-checking bench for seg7_to_tc4: directed scenarios for timing, hold,
// saturation and reset behaviour, followed by a randomized phase where a
// reference decode pushes expected results into a queue and an independent
// monitor pops and compares them on every handshake.
// -----------------------------------------------------------------------------
module tb_seg7_to_tc4;

    localparam int STABLE = 4;

    localparam logic [6:0] S_POS = 7'b1111111;
    localparam logic [6:0] S_NEG = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [6:0] Sign;
    logic [6:0] Magnitude;
    logic       Ready;
    logic [3:0] N;
    logic       Valid;
    logic       Error;
    logic [3:0] ErrCount;

    seg7_to_tc4 #(.STABLE_CYCLES(STABLE)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Sign      (Sign),
        .Magnitude (Magnitude),
        .Ready     (Ready),
        .N         (N),
        .Valid     (Valid),
        .Error     (Error),
        .ErrCount  (ErrCount)
    );

    always #5 Clock = ~Clock;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0] n;
        logic       err;
    } result_t;

    result_t    sb_q[$];
    bit         sb_en   = 1'b0;
    int         accepts = 0;
    int         exp_ec  = 0;

    // Digit table indexed by the value it displays.
    logic [6:0] digits [9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the encoding rules: find the digit value,
    // then accept +0..+7 and -1..-8, everything else is an error with N=0.
    function automatic result_t model(input logic [6:0] s, input logic [6:0] m);
        result_t r;
        int v = -1;
        for (int i = 0; i < 9; i++) begin
            if (m == digits[i]) v = i;
        end
        r.n   = 4'd0;
        r.err = 1'b1;
        if (s == S_POS && v >= 0 && v <= 7) begin
            r.n   = 4'(v);
            r.err = 1'b0;
        end else if (s == S_NEG && v >= 1 && v <= 8) begin
            r.n   = 4'(16 - v);
            r.err = 1'b0;
        end
        return r;
    endfunction

    task automatic do_reset();
        Reset     = 1'b1;
        Ready     = 1'b0;
        Sign      = S_POS;
        Magnitude = BLANK;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        Reset = 1'b0;
    endtask

    // Waits (at falling edges) for Valid, bounded by budget cycles.
    task automatic wait_valid(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            if (Valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Scoreboard monitor: every handshake pops one expected result.
    always @(negedge Clock) begin
        if (sb_en && Valid && Ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'(Valid), 32'd0);
            end else begin
                result_t e;
                e = sb_q.pop_front();
                check("sb_n", 32'(N), 32'(e.n));
                check("sb_error", 32'(Error), 32'(e.err));
                check("sb_errcount", 32'(ErrCount), 32'(exp_ec));
                if (e.err && exp_ec < 15) exp_ec++;
            end
            accepts++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit      got;
        logic    v0;
        logic [3:0] n0;
        int      seen;

        // ---------------- reset state and stability timing ----------------
        do_reset();
        @(negedge Clock);
        check("reset_valid", 32'(Valid), 32'd0);
        check("reset_n", 32'(N), 32'd0);
        check("reset_error", 32'(Error), 32'd0);
        check("reset_errcount", 32'(ErrCount), 32'd0);

        Sign = S_POS; Magnitude = 7'b0010010; Ready = 1'b1;
        for (int e = 0; e <= 4; e++) begin
            @(negedge Clock);
            check($sformatf("t030_valid_e%0d", e), 32'(Valid), 32'(e == 3));
            if (e == 3) begin
                check("t030_n", 32'(N), 32'h5);
                check("t030_error", 32'(Error), 32'd0);
            end
        end

        // ---------------- negative values ----------------
        Sign = S_NEG; Magnitude = 7'b0000000;
        wait_valid(12, got);
        check("t031a_got", 32'(got), 32'd1);
        check("t031a_n", 32'(N), 32'h8);
        check("t031a_error", 32'(Error), 32'd0);
        @(negedge Clock);
        check("t031a_drop", 32'(Valid), 32'd0);

        Magnitude = 7'b1111001;
        wait_valid(12, got);
        check("t031b_got", 32'(got), 32'd1);
        check("t031b_n", 32'(N), 32'hF);
        check("t031b_error", 32'(Error), 32'd0);
        @(negedge Clock);

        // ---------------- hold while Ready is low ----------------
        Ready = 1'b0; Sign = S_POS; Magnitude = 7'b0110000;
        wait_valid(12, got);
        check("t032_got", 32'(got), 32'd1);
        for (int i = 0; i < 5; i++) begin
            Magnitude = 7'($urandom);
            @(negedge Clock);
            check("t032_hold_valid", 32'(Valid), 32'd1);
            check("t032_hold_n", 32'(N), 32'h3);
            check("t032_hold_error", 32'(Error), 32'd0);
        end
        Ready = 1'b1;
        @(negedge Clock);
        check("t032_drop", 32'(Valid), 32'd0);
        check("t032_errcount", 32'(ErrCount), 32'd0);

        // ---------------- pair changes before becoming stable ----------------
        do_reset();
        @(negedge Clock);
        Ready = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            Sign      = S_POS;
            Magnitude = (e < 2) ? 7'b0011001 : 7'b1111000;
            @(negedge Clock);
            check($sformatf("t033_valid_e%0d", e), 32'(Valid), 32'(e == 5));
            if (e == 5) check("t033_n", 32'(N), 32'h7);
        end

        // ---------------- error counting and saturation ----------------
        do_reset();
        @(negedge Clock);
        Ready = 1'b1;
        for (int r = 0; r < 20; r++) begin
            Sign = S_POS; Magnitude = 7'b0000000;
            wait_valid(12, got);
            check("t034_got", 32'(got), 32'd1);
            if (r == 0) begin
                check("t034_error", 32'(Error), 32'd1);
                check("t034_n", 32'(N), 32'h0);
            end
            @(negedge Clock);
            if (r == 0) check("t034_errcount1", 32'(ErrCount), 32'd1);
            Magnitude = BLANK;
            @(negedge Clock);
            @(negedge Clock);
        end
        check("t034_errcount_sat", 32'(ErrCount), 32'd15);

        // ---------------- reset during OFFER, blank never offered ----------------
        Ready = 1'b0; Sign = S_POS; Magnitude = 7'b0000010;
        wait_valid(12, got);
        check("t035_got", 32'(got), 32'd1);
        v0 = Valid; n0 = N;
        check("t035_pre_n", 32'(n0), 32'h6);
        Reset = 1'b1; Ready = 1'b1; Magnitude = 7'b0000000;
        @(negedge Clock);
        check("t035_valid", 32'(Valid), 32'd0);
        check("t035_errcount", 32'(ErrCount), 32'd0);
        check("t035_n", 32'(N), 32'd0);
        Reset = 1'b0; Magnitude = BLANK;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            Sign = (i < 5) ? S_POS : S_NEG;
            @(negedge Clock);
            if (Valid) seen++;
        end
        check("t035_blank_valid", 32'(seen), 32'd0);

        // ---------------- randomized scoreboard phase ----------------
        do_reset();
        exp_ec = 0;
        sb_en  = 1'b1;
        for (int t = 0; t < 60; t++) begin
            int sr_sel;
            int target;
            logic [6:0] s, m;
            bit done;
            sr_sel = $urandom_range(0, 9);
            s = (sr_sel < 4) ? S_POS : (sr_sel < 8) ? S_NEG : 7'($urandom);
            if ($urandom_range(0, 9) < 8) m = digits[$urandom_range(0, 8)];
            else                         m = 7'($urandom);
            if (m == BLANK) m = 7'b0101010;
            sb_q.push_back(model(s, m));
            target    = accepts + 1;
            Sign      = s;
            Magnitude = m;
            Ready     = 1'($urandom_range(0, 1));
            done      = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(posedge Clock); #1;
                if (accepts == target) begin
                    done = 1'b1;
                    break;
                end
                Ready = 1'($urandom_range(0, 1));
            end
            if (!done) begin
                check("accept_timeout", 32'd0, 32'd1);
                sb_q.delete();
            end
            Magnitude = BLANK;
            Sign      = ($urandom_range(0, 1) == 0) ? S_POS : S_NEG;
            Ready     = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3)) begin
                @(posedge Clock); #1;
            end
        end
        @(negedge Clock);
        sb_en = 1'b0;
        check("sb_final_errcount", 32'(ErrCount), 32'(exp_ec));
        check("sb_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
